// File: rtl/shift_right_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_ctrl_pkg
// Description : Shared definitions for the button-driven shifter blocks.
//               Holds the controller state encoding and the default
//               parameter values. The left-shift controller uses it too.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_right_ctrl_pkg;

  // Result register width; the operand is one bit narrower.
  localparam int W_DEFAULT = 4;

  // Stable clk cycles a button level must hold before it is accepted.
  localparam int DB_CYCLES_DEFAULT = 250000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    EMPTY  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_right_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_ctrl_if
// Description : Operand, button and result bundle of the right shifter.
//   portB     : operand, W-1 bits, sampled only on an accepted load
//   load_btn  : raw load pushbutton (asynchronous, bouncy)
//   step_btn  : raw step pushbutton (asynchronous, bouncy)
//   sal_sh_r  : current shifted value, W bits
//   shift_cnt : shifts applied since the last load
//   busy/done : state decodes (LOADED / EMPTY)
//   master drives operand and buttons; slave is the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_right_ctrl_if
  import shift_right_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic [W-2:0] portB;
  logic         load_btn;
  logic         step_btn;
  logic [W-1:0] sal_sh_r;
  logic [2:0]   shift_cnt;
  logic         busy;
  logic         done;

  modport master (
    output portB, load_btn, step_btn,
    input  sal_sh_r, shift_cnt, busy, done
  );

  modport slave (
    input  portB, load_btn, step_btn,
    output sal_sh_r, shift_cnt, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/shift_right_ctrl_btn_cond.sv
`default_nettype none
// ============================================================================
// Module      : btn_cond
// Description : Pushbutton conditioner: 2-flop synchronizer, debounce
//               counter, rising-edge detector. Emits a single-cycle pulse
//               per accepted press; releases and short glitches are silent.
//   clk   : system clock
//   rst   : synchronous active-high reset (clears to "released")
//   btn   : raw asynchronous button level
//   pulse : one-cycle pulse on an accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_cond
  import shift_right_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn,
  output logic      pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= stable;
      // cnt tracks how many consecutive samples have disagreed with the
      // accepted level; any agreeing sample restarts the run.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Built only from registers, so there is no combinational path from btn.
  assign pulse = stable & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/shift_right_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_ctrl
// Description : Loads a (W-1)-bit operand MSB-aligned into a W-bit register
//               and shifts it right one place per debounced step press.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : shift_right_ctrl_if slave (operand, buttons, result, status)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_ctrl
  import shift_right_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int W         = W_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  shift_right_ctrl_if.slave bus
);

  logic         load_p;
  logic         step_p;

  state_t       state_r;
  state_t       state_nx;
  logic [W-1:0] value_r;
  logic [W-1:0] value_nx;
  logic [2:0]   cnt_r;
  logic [2:0]   cnt_nx;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_load_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.load_btn),
    .pulse (load_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_step_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.step_btn),
    .pulse (step_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      value_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      value_r <= value_nx;
      cnt_r   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_r;
    value_nx = value_r;
    cnt_nx   = cnt_r;
    // Load is checked first so a coincident step is dropped.
    if (load_p) begin
      value_nx = {bus.portB, 1'b0};
      cnt_nx   = '0;
      state_nx = (bus.portB != '0) ? LOADED : EMPTY;
    end else if (step_p && (state_r == LOADED)) begin
      value_nx = value_r >> 1;
      cnt_nx   = cnt_r + 3'd1;
      state_nx = (value_nx == '0) ? EMPTY : LOADED;
    end
  end

  assign bus.sal_sh_r  = value_r;
  assign bus.shift_cnt = cnt_r;
  assign bus.busy      = (state_r == LOADED);
  assign bus.done      = (state_r == EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_shift_right_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_right_ctrl
// Description : Directed self-checking bench for shift_right_ctrl with a
//               short debounce window (DB_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_right_ctrl;

  localparam int DB = 4;
  localparam int WW = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  shift_right_ctrl_if #(.W(WW)) bus ();

  shift_right_ctrl #(.DB_CYCLES(DB), .W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press step cleanly: held 10 cycles, then 10 released cycles.
  task automatic press_step();
    bus.step_btn = 1'b1;
    tick(10);
    bus.step_btn = 1'b0;
    tick(10);
  endtask

  task automatic press_load(input logic [WW-2:0] op);
    bus.portB    = op;
    bus.load_btn = 1'b1;
    tick(10);
    bus.load_btn = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.portB = '0;
    bus.load_btn = 1'b0;
    bus.step_btn = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset: got sal=%b cnt=%0d busy=%b done=%b, want all 0",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_load();
    int lat;
    lat = 0;
    bus.portB    = 3'b101;
    bus.load_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.sal_sh_r == 4'b1010) begin
        lat = k;
        break;
      end
    end
    // 2 sync edges + DB counting edges sets the level, one more edge loads.
    n_checks++;
    if (lat !== DB + 3) begin
      n_fail++;
      $display("FAIL load_latency: got %0d edges, want %0d", lat, DB + 3);
    end
    tick(10 - (lat == 0 ? 10 : lat));
    bus.load_btn = 1'b0;
    tick(10);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== {4'b1010, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL load_101: got sal=%b cnt=%0d busy=%b done=%b, want 1010 0 1 0",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_steps();
    logic [3:0] exp_val [4];
    exp_val[0] = 4'b0101;
    exp_val[1] = 4'b0010;
    exp_val[2] = 4'b0001;
    exp_val[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      press_step();
      n_checks++;
      if (bus.sal_sh_r !== exp_val[i] || bus.shift_cnt !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL step_%0d: got sal=%b cnt=%0d, want sal=%b cnt=%0d",
                 i + 1, bus.sal_sh_r, bus.shift_cnt, exp_val[i], i + 1);
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_flags: got busy=%b done=%b, want 0 1", bus.busy, bus.done);
    end
    press_step();
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== {4'b0000, 3'd4, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL step_in_empty: got sal=%b cnt=%0d busy=%b done=%b, want 0000 4 0 1",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_bounce();
    press_load(3'b101);
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      tick(2);
    end
    bus.step_btn = 1'b0;
    tick(2);
    n_checks++;
    if (bus.sal_sh_r !== 4'b1010 || bus.shift_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL bounce_only: got sal=%b cnt=%0d, want 1010 0",
               bus.sal_sh_r, bus.shift_cnt);
    end
    bus.step_btn = 1'b1;
    tick(10);
    bus.step_btn = 1'b0;
    tick(10);
    n_checks++;
    if (bus.sal_sh_r !== 4'b0101 || bus.shift_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL bounce_then_hold: got sal=%b cnt=%0d, want 0101 1",
               bus.sal_sh_r, bus.shift_cnt);
    end
  endtask

  task automatic test_load_wins();
    // State is LOADED with 0101 and one shift; a lost load would give 0010.
    bus.portB    = 3'b111;
    bus.load_btn = 1'b1;
    bus.step_btn = 1'b1;
    tick(10);
    bus.load_btn = 1'b0;
    bus.step_btn = 1'b0;
    tick(10);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy} !== {4'b1110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_wins: got sal=%b cnt=%0d busy=%b, want 1110 0 1",
               bus.sal_sh_r, bus.shift_cnt, bus.busy);
    end
  endtask

  task automatic test_zero_load();
    press_load(3'b000);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load: got sal=%b cnt=%0d busy=%b done=%b, want 0000 0 0 1",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
    press_step();
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_step: got sal=%b cnt=%0d busy=%b done=%b, want 0000 0 0 1",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_mid_reset();
    press_load(3'b101);
    bus.step_btn = 1'b1;
    tick(3);
    rst = 1'b1;
    bus.step_btn = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got sal=%b cnt=%0d busy=%b done=%b, want all 0",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
    rst = 1'b0;
    tick(15);
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== 9'd0) begin
      n_fail++;
      $display("FAIL after_reset_idle: got sal=%b cnt=%0d busy=%b done=%b, want all 0",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
    press_step();
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done} !== 9'd0) begin
      n_fail++;
      $display("FAIL step_in_idle: got sal=%b cnt=%0d busy=%b done=%b, want all 0",
               bus.sal_sh_r, bus.shift_cnt, bus.busy, bus.done);
    end
    press_load(3'b101);
    press_step();
    n_checks++;
    if ({bus.sal_sh_r, bus.shift_cnt, bus.busy} !== {4'b0101, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL fresh_press: got sal=%b cnt=%0d busy=%b, want 0101 1 1",
               bus.sal_sh_r, bus.shift_cnt, bus.busy);
    end
  endtask

  task automatic test_held_through_reset();
    logic seen;
    seen = 1'b0;
    rst = 1'b1;
    bus.portB    = 3'b011;
    bus.load_btn = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (bus.sal_sh_r == 4'b0110) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_through_reset: got sal=%b busy=%b within 20 cycles, want 0110 1",
               bus.sal_sh_r, bus.busy);
    end
    tick(10);
    bus.load_btn = 1'b0;
    tick(10);
    n_checks++;
    if (bus.sal_sh_r !== 4'b0110 || bus.shift_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL held_single_pulse: got sal=%b cnt=%0d, want 0110 0",
               bus.sal_sh_r, bus.shift_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.portB    = '0;
    bus.load_btn = 1'b0;
    bus.step_btn = 1'b0;
    test_reset();
    test_load();
    test_steps();
    test_bounce();
    test_load_wins();
    test_zero_load();
    test_mid_reset();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_right_ctrl.md
SHIFT_RIGHT_CTRL -- requirements
Module: shift_right_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 250000, is the number of consecutive stable clk cycles a button level must hold before it is accepted.
REQ-002 Parameter W, default 4, is the result register width; the operand width is W-1.
REQ-003 clk, input, 1, is the system clock; every register updates on its rising edge.
REQ-004 rst, input, 1, is the reset: synchronous, active-high, sampled on rising clk.
REQ-005 portB, input, W-1 (3), is the operand to be shifted right; it is asynchronous and only sampled on an accepted load.
REQ-006 load_btn, input, 1, is the raw pushbutton that loads the operand; it is asynchronous and bouncy.
REQ-007 step_btn, input, 1, is the raw pushbutton that requests one right shift; it is asynchronous and bouncy.
REQ-008 sal_sh_r, output, W (4), is the current shifted value.
REQ-009 shift_cnt, output, 3, is the number of shifts applied since the last load.
REQ-010 busy, output, 1, is high while the value is nonzero and further shifts are meaningful.
REQ-011 done, output, 1, is high once the value has shifted out to zero (state EMPTY).

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter that accepts a new level only after DB_CYCLES consecutive identical samples, then a rising-edge detector producing a 1-cycle pulse (load_p, step_p).
REQ-013 A button release, or a press shorter than DB_CYCLES, SHALL produce no pulse.
REQ-014 Holding a button SHALL produce exactly one pulse per press.
REQ-015 The FSM SHALL have three states: IDLE, LOADED and EMPTY.
REQ-016 In any state, load_p SHALL set sal_sh_r = {portB,1'b0} (MSB-aligned) and shift_cnt = 0 at the next edge.
REQ-017 On load_p, the next state SHALL be LOADED if portB != 0, and EMPTY otherwise.
REQ-018 In LOADED, step_p SHALL cause sal_sh_r <= sal_sh_r >> 1 (logical, zero-fill MSB) and shift_cnt <= shift_cnt + 1 at the next edge.
REQ-019 On step_p in LOADED, the next state SHALL be EMPTY when the shifted result is 0, and LOADED otherwise.
REQ-020 In IDLE and EMPTY, step_p SHALL be ignored: value and shift_cnt hold, and shift_cnt never exceeds W.
REQ-021 If load_p and step_p occur in the same cycle, load SHALL win and the step is discarded.
REQ-022 Latency: sal_sh_r SHALL update exactly one clk after the pulse cycle, which itself lags a clean press by 2 + DB_CYCLES cycles.
REQ-023 Output decode: busy = (state == LOADED), done = (state == EMPTY); both SHALL be registered-state decodes with no combinational path from the buttons.
REQ-024 In the same cycle as the update, shift_cnt SHALL equal the number of accepted steps since the last load.

Reset
REQ-025 On rst, the block SHALL set sal_sh_r = 0, shift_cnt = 0, state = IDLE, busy = 0, done = 0.
REQ-026 On rst, the synchronizer flops, debounce counters and stable levels SHALL clear to 0 (released).
REQ-027 rst SHALL take priority over load_p and step_p in the same cycle.
REQ-028 A button held through reset SHALL generate one pulse after DB_CYCLES stable cycles following rst deassertion.
REQ-029 rst asserted mid-debounce SHALL abort the pending press with no pulse.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, LOADED, EMPTY), the W default and the DB_CYCLES default; the package is shared with the left shifter.
REQ-031 One sub-module, btn_cond (synchronizer + debounce + edge detect, parameter DB_CYCLES), SHALL be instantiated twice.
REQ-032 The FSM and datapath SHALL live in shift_right_ctrl.

Verification (bench uses DB_CYCLES = 4)
REQ-033 Scenario 1: rst, then portB = 3'b101, load held 10 cycles -> sal_sh_r = 4'b1010, shift_cnt = 0, busy = 1, done = 0, one cycle after the pulse.
REQ-034 Scenario 2: continuing scenario 1, four clean step presses -> sal_sh_r = 1010, 0101, 0010, 0001, 0000; after the 4th, done = 1, busy = 0, shift_cnt = 4; a 5th press leaves all values unchanged.
REQ-035 Scenario 3: step_btn toggling every 2 cycles for 20 cycles, then held 10 cycles -> exactly one shift.
REQ-036 Scenario 4: load and step pulses forced into the same cycle with portB = 3'b111 -> sal_sh_r = 4'b1110, shift_cnt = 0.
REQ-037 Scenario 5: portB = 0 loaded -> sal_sh_r = 0, done = 1 immediately; a step press is ignored.
REQ-038 Scenario 6: rst pulsed while in LOADED with a step press mid-debounce -> all outputs 0, state IDLE, no shift after rst release until a fresh press.
